// File: rtl/eq_pkg.sv
// eq_pkg: shared types for the equivalence stream comparator.
//   state_t    - run-control FSM states (IDLE, RUN, PASS, FAIL)
//   CAUSE_*    - fail_cause codes reported by eq_stream_cmp
package eq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_DATA = 2'd1;
   localparam logic [1:0] CAUSE_SKEW = 2'd2;

endpackage

// File: rtl/eq_skew_fifo.sv
// eq_skew_fifo: small synchronous FIFO that absorbs the skew between one
// compared design and its partner.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               empties the FIFO (pointers and occupancy to 0)
//   push, push_data     write one entry (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   head                current head entry (only meaningful when !empty)
//   full, empty         occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module eq_skew_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         // simultaneous push and pop leave occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset: entries are only read while count says valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/eq_stream_cmp.sv
// eq_stream_cmp: lock-step equivalence checker for two output streams
// (design A = ILA model, design B = HLS RTL). Each stream is buffered in its
// own skew FIFO; whenever both heads are present they are popped together and
// compared. A run ends in PASS after cfg_len equal pairs (cfg_len=0: never),
// or in FAIL on a data mismatch or when one side leads for TIMEOUT cycles.
//
// Handshake: a beat transfers on a rising ap_clk edge where x_tvalid and
// x_tready are both 1; x_tready depends only on internal state, never on
// x_tvalid, and x_tvalid may be asserted at any time.
//
// Ports:
//   ap_clk, ap_rst_n        clock, async active-low reset (release synchronised)
//   start, cfg_len          run start pulse, pair count (0 = unlimited)
//   a_* / b_*               input streams and their ready outputs
//   a_step, b_step          clock-enable for each design (0 = freeze it)
//   busy, pass, fail        status: RUN, PASS, FAIL
//   fail_cause, fail_idx    why and at which pair index the run failed
//   fail_a_data/_b_data     head data captured at failure
//   cmp_cnt                 pairs compared equal in this run (saturating)
//   state_dbg               current FSM state, for observation
module eq_stream_cmp
   import eq_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic [DATA_W-1:0] a_tdata,
   input  logic              a_tvalid,
   output logic              a_tready,
   input  logic [DATA_W-1:0] b_tdata,
   input  logic              b_tvalid,
   output logic              b_tready,
   output logic              a_step,
   output logic              b_step,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_cause,
   output logic [CNT_W-1:0]  fail_idx,
   output logic [DATA_W-1:0] fail_a_data,
   output logic [DATA_W-1:0] fail_b_data,
   output logic [CNT_W-1:0]  cmp_cnt,
   output logic [1:0]        state_dbg
);

   localparam int SKEW_W = $clog2(TIMEOUT + 1);

   state_t             state_q, state_nxt;
   logic [1:0]         rst_sync_q;
   logic               run_ok;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic [1:0]         cause_q;
   logic [CNT_W-1:0]   idx_q;
   logic [DATA_W-1:0]  fa_q, fb_q;
   logic [SKEW_W-1:0]  skew_q;

   logic               in_run;
   logic               start_ok;
   logic               a_full, a_empty, b_full, b_empty;
   logic [DATA_W-1:0]  a_head, b_head;
   logic               a_push, b_push;
   logic               cmp_fire;
   logic               heads_eq;
   logic               skew_lead;
   logic               skew_fire;

   // Assertion of ap_rst_n clears everything at once; its release reaches the
   // FSM only after two ap_clk edges, so a start cannot race the release.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) rst_sync_q <= '0;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign run_ok = rst_sync_q[1];

   assign in_run    = (state_q == ST_RUN);
   assign start_ok  = start && run_ok && !in_run;
   assign a_tready  = in_run && !a_full;
   assign b_tready  = in_run && !b_full;
   assign a_step    = a_tready;
   assign b_step    = b_tready;
   assign a_push    = a_tvalid && a_tready;
   assign b_push    = b_tvalid && b_tready;
   assign cmp_fire  = in_run && !a_empty && !b_empty;
   assign heads_eq  = (a_head == b_head);
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign skew_lead = in_run && (a_empty != b_empty);
   assign skew_fire = skew_lead && (skew_q == SKEW_W'(TIMEOUT - 1));

   eq_skew_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .flush     (start_ok),
      .push      (a_push),
      .push_data (a_tdata),
      .pop       (cmp_fire),
      .head      (a_head),
      .full      (a_full),
      .empty     (a_empty)
   );

   eq_skew_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .flush     (start_ok),
      .push      (b_push),
      .push_data (b_tdata),
      .pop       (cmp_fire),
      .head      (b_head),
      .full      (b_full),
      .empty     (b_empty)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_q <= ST_IDLE;
      else           state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start_ok) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (cmp_fire) begin
               if (!heads_eq)                                state_nxt = ST_FAIL;
               else if ((len_q != '0) && (cnt_inc == len_q)) state_nxt = ST_PASS;
            end else if (skew_fire) begin
               state_nxt = ST_FAIL;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Result and bookkeeping registers. Compare and skew timeout are mutually
   // exclusive: a compare needs both FIFOs occupied, the skew counter exactly one.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         len_q   <= '0;
         cnt_q   <= '0;
         cause_q <= CAUSE_NONE;
         idx_q   <= '0;
         fa_q    <= '0;
         fb_q    <= '0;
         skew_q  <= '0;
      end else if (start_ok) begin
         len_q   <= cfg_len;
         cnt_q   <= '0;
         cause_q <= CAUSE_NONE;
         idx_q   <= '0;
         fa_q    <= '0;
         fb_q    <= '0;
         skew_q  <= '0;
      end else if (in_run) begin
         if (cmp_fire) begin
            skew_q <= '0;
            if (heads_eq) begin
               if (cnt_q != '1) cnt_q <= cnt_inc;
            end else begin
               cause_q <= CAUSE_DATA;
               idx_q   <= cnt_q;
               fa_q    <= a_head;
               fb_q    <= b_head;
            end
         end else if (skew_lead) begin
            skew_q <= skew_q + SKEW_W'(1);
            if (skew_fire) begin
               cause_q <= CAUSE_SKEW;
               idx_q   <= cnt_q;
               fa_q    <= a_empty ? '0 : a_head;
               fb_q    <= b_empty ? '0 : b_head;
            end
         end else begin
            skew_q <= '0;
         end
      end else begin
         skew_q <= '0;
      end
   end

   assign busy        = in_run;
   assign pass        = (state_q == ST_PASS);
   assign fail        = (state_q == ST_FAIL);
   assign fail_cause  = cause_q;
   assign fail_idx    = idx_q;
   assign fail_a_data = fa_q;
   assign fail_b_data = fb_q;
   assign cmp_cnt     = cnt_q;
   assign state_dbg   = state_q;

endmodule
